// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag/data path: address geometry,
// address field slicing helpers and the refill FSM state type. Used by the
// refill controller, the tag RAM and the lookup logic.
package cache_pkg;

  localparam int ADDR_W   = 8;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 1;
  localparam int DATA_W   = 64;
  localparam int BEATS    = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_t;

  // address = {tag, index, offset}
  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: write side of the tag/data arrays.
// On a miss it requests the whole line from memory, writes each returned beat
// into the data RAM and finally writes the new tag. The tag goes in last so a
// half-filled line can never hit.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   miss, miss_addr  lookup miss and its address, sampled only when idle
//   busy             refill in progress, upstream stalls
//   mem_req_*        line read request (valid/ready), line-aligned address
//   mem_rsp_*        returned beats, in order, no backpressure
//   data_we/waddr/wdata   data RAM write port, waddr = {index, beat}
//   tag_we/waddr/wdata    tag RAM write port, one-cycle strobe
//   refill_done      one-cycle pulse when the line is installed
//
// Request handshake: mem_req_valid rises once the miss is latched and holds,
// with mem_req_addr stable, until the cycle where mem_req_ready is also high;
// the transfer happens on that clock edge and valid drops afterwards.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         busy,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_W-1:0]            mem_rsp_data,
  output logic                         data_we,
  output logic [INDEX_W+OFFSET_W-1:0]  data_waddr,
  output logic [DATA_W-1:0]            data_wdata,
  output logic                         tag_we,
  output logic [INDEX_W-1:0]           tag_waddr,
  output logic [TAG_W-1:0]             tag_wdata,
  output logic                         refill_done
);

  // Clears the beat offset so the request always targets the line start.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS - 1);

  refill_state_t         state;
  logic [OFFSET_W-1:0]   beat_cnt;
  logic [TAG_W-1:0]      tag_q;
  logic [INDEX_W-1:0]    index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      tag_q         <= '0;
      index_q       <= '0;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      data_we       <= 1'b0;
      data_waddr    <= '0;
      data_wdata    <= '0;
      tag_we        <= 1'b0;
      tag_waddr     <= '0;
      tag_wdata     <= '0;
      refill_done   <= 1'b0;
    end else begin
      // Strobes default low; only the owning state raises them for one cycle.
      data_we     <= 1'b0;
      tag_we      <= 1'b0;
      refill_done <= 1'b0;

      case (state)
        IDLE: begin
          // The cycle that shows refill_done is IDLE already, but a miss seen
          // there belongs to the old line's lookup, so it is not taken.
          if (miss && !refill_done) begin
            tag_q         <= get_tag(miss_addr);
            index_q       <= get_index(miss_addr);
            beat_cnt      <= '0;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= miss_addr & LINE_MASK;
            busy          <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL;
          end
        end

        FILL: begin
          // Beats arrive in order, possibly with gaps; wait indefinitely.
          if (mem_rsp_valid) begin
            data_we    <= 1'b1;
            data_waddr <= {index_q, beat_cnt};
            data_wdata <= mem_rsp_data;
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == OFFSET_W'(BEATS - 1)) begin
              state <= COMMIT;
            end
          end
        end

        COMMIT: begin
          tag_we      <= 1'b1;
          tag_waddr   <= index_q;
          tag_wdata   <= tag_q;
          refill_done <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios plus randomized refills.
// The driver pushes the expected memory request, data writes and tag write
// for every miss it issues; an independent monitor pops and compares them
// whenever the DUT shows a handshake or a write strobe.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int DW_E = INDEX_W + OFFSET_W + DATA_W;
  localparam int TW_E = INDEX_W + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                        miss = 1'b0;
  logic [ADDR_W-1:0]           miss_addr = '0;
  logic                        busy;
  logic                        mem_req_valid;
  logic                        mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic                        mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0]           mem_rsp_data = '0;
  logic                        data_we;
  logic [INDEX_W+OFFSET_W-1:0] data_waddr;
  logic [DATA_W-1:0]           data_wdata;
  logic                        tag_we;
  logic [INDEX_W-1:0]          tag_waddr;
  logic [TAG_W-1:0]            tag_wdata;
  logic                        refill_done;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss          (miss),
    .miss_addr     (miss_addr),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .data_we       (data_we),
    .data_waddr    (data_waddr),
    .data_wdata    (data_wdata),
    .tag_we        (tag_we),
    .tag_waddr     (tag_waddr),
    .tag_wdata     (tag_wdata),
    .refill_done   (refill_done)
  );

  wire [88:0] all_outs = {busy, mem_req_valid, mem_req_addr, data_we, data_waddr,
                          data_wdata, tag_we, tag_waddr, tag_wdata, refill_done};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_req_q[$];
  logic [DW_E-1:0]   exp_data_q[$];
  logic [TW_E-1:0]   exp_tag_q[$];
  int n_exp_hs   = 0;
  int n_exp_done = 0;
  int n_hs       = 0;
  int n_done     = 0;
  int miss_cyc   = 0;
  bit check_lat  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit                hs_seen = 1'b0;
  bit                prev_valid = 1'b0;
  bit                prev_ready = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int                line_writes = 0;
  int                last_we_cyc = -10;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_seen     = 1'b0;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
      line_writes = 0;
    end else begin
      // A pending request must hold valid and address until accepted.
      if (prev_valid && !prev_ready) begin
        check("req_hold_valid", mem_req_valid, 1);
        check("req_hold_addr", mem_req_addr, prev_addr);
      end
      if (mem_req_valid && mem_req_ready) begin
        n_hs++;
        if (exp_req_q.size() == 0) check("req_unexpected", mem_req_valid, 0);
        else check("req_addr", mem_req_addr, exp_req_q.pop_front());
        hs_seen = 1'b1;
      end
      if (data_we) begin
        check("data_after_handshake", hs_seen, 1);
        if (exp_data_q.size() == 0) check("data_we_unexpected", data_we, 0);
        else check("data_write", {data_waddr, data_wdata}, exp_data_q.pop_front());
        line_writes++;
        last_we_cyc = cyc;
      end
      if (tag_we || refill_done) check("done_with_tag", refill_done, tag_we);
      if (tag_we) begin
        if (exp_tag_q.size() == 0) check("tag_we_unexpected", tag_we, 0);
        else check("tag_write", {tag_waddr, tag_wdata}, exp_tag_q.pop_front());
        check("tag_after_last_write", cyc, last_we_cyc + 1);
        check("writes_per_line", line_writes, BEATS);
        if (check_lat) check("tag_latency", cyc - miss_cyc, BEATS + 3);
        line_writes = 0;
        hs_seen     = 1'b0;
        n_done++;
      end
      prev_valid = mem_req_valid;
      prev_ready = mem_req_ready;
      prev_addr  = mem_req_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || refill_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", busy, 0);
  endtask

  // mode: 0 random data, 1 fixed 1111../2222.. data, 2 miss pulse during FILL,
  //       3 reset after beat 0
  task automatic do_refill(input logic [ADDR_W-1:0] a, input int rdly, input int gap,
                           input int mode);
    logic [DATA_W-1:0] d[BEATS];
    int idx, tg, n;
    idx = (int'(a) >> OFFSET_W) % (1 << INDEX_W);
    tg  = int'(a) >> (ADDR_W - TAG_W);
    for (int b = 0; b < BEATS; b++) begin
      if (mode == 1) d[b] = {16{4'(b + 1)}};
      else d[b] = {$urandom(), $urandom()};
    end
    wait_idle();

    exp_req_q.push_back(ADDR_W'(int'(a) - (int'(a) % BEATS)));
    n_exp_hs++;
    for (int b = 0; b < BEATS; b++) begin
      if (mode != 3 || b == 0)
        exp_data_q.push_back({(INDEX_W+OFFSET_W)'(idx * BEATS + b), d[b]});
    end
    if (mode != 3) begin
      exp_tag_q.push_back({INDEX_W'(idx), TAG_W'(tg)});
      n_exp_done++;
    end

    @(posedge clk); #1;
    miss          = 1'b1;
    miss_addr     = a;
    miss_cyc      = cyc;
    mem_req_ready = (rdly == 0);
    @(posedge clk); #1;
    miss      = 1'b0;
    miss_addr = ADDR_W'($urandom());
    repeat (rdly) begin
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    n = 0;
    while (!(mem_req_valid && mem_req_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("req_timeout", mem_req_valid, 1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d[b];
      if (mode == 2 && b == 0) begin
        miss      = 1'b1;
        miss_addr = 8'h3C;
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom(), $urandom()};
      miss          = 1'b0;
      if (mode == 3) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs, 0);
        exp_data_q.delete();
        exp_tag_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_outputs", all_outs, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_req", mem_req_valid, 0);
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    check("reset_outputs", all_outs, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_outputs", all_outs, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);

    // basic refill with minimum latency
    check_lat = 1'b1;
    do_refill(8'hA5, 0, 0, 0);
    wait_idle();
    check_lat = 1'b0;

    // request backpressure
    do_refill(8'h57, 4, 0, 0);
    // gaps between beats, fixed data
    do_refill(8'h12, 0, 3, 1);
    // miss during FILL is ignored, then retried
    do_refill(8'hE9, 1, 1, 2);
    do_refill(8'h3C, 0, 0, 0);
    // reset in the middle of FILL
    do_refill(8'h6B, 0, 2, 3);

    // spurious response while idle
    wait_idle();
    @(posedge clk); #1;
    repeat (3) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {$urandom(), $urandom()};
      @(posedge clk); #1;
      check("spurious_busy", busy, 0);
      check("spurious_req", mem_req_valid, 0);
    end
    mem_rsp_valid = 1'b0;

    // randomized refills
    for (int i = 0; i < 24; i++) begin
      do_refill(ADDR_W'($urandom()), $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("req_q_drained", exp_req_q.size(), 0);
    check("data_q_drained", exp_data_q.size(), 0);
    check("tag_q_drained", exp_tag_q.size(), 0);
    check("handshake_count", n_hs, n_exp_hs);
    check("done_count", n_done, n_exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
